// File: rtl/int_mul_iter_var_pkg.sv
// Shared types and default sizing for the iterative variable-latency multiplier.
package int_mul_iter_var_pkg;

  localparam int unsigned NBits    = 32;
  localparam int unsigned MaxShift = 4;
  // Width needed to encode a shift amount of 0..MaxShift
  localparam int unsigned ShamtW   = $clog2(MaxShift + 1);
  // Request message carries {a, b}
  localparam int unsigned MsgW     = 2 * NBits;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_t;

endpackage

// File: rtl/int_mul_iter_var_dpath.sv
// Shift-and-add datapath: operand/result registers, adder, shifters and the
// saturating trailing-zero encoder that lets runs of zeros in b be skipped.
module int_mul_iter_var_dpath
  import int_mul_iter_var_pkg::*;
#(
  parameter int unsigned p_nbits     = NBits,
  parameter int unsigned p_max_shift = MaxShift
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               calc,
  input  logic [p_nbits-1:0] in_a,
  input  logic [p_nbits-1:0] in_b,
  output logic               b_is_zero,
  output logic               b_next_is_zero,
  output logic               b_lsb,
  output logic [p_nbits-1:0] result
);

  localparam int unsigned ShW = $clog2(p_max_shift + 1);

  logic [p_nbits-1:0] a_reg, b_reg, result_reg;
  logic [p_nbits-1:0] a_shl, b_shr, sum;
  logic [ShW-1:0]     tz, shamt;

  // Trailing-zero count of the low p_max_shift bits of b, saturated at p_max_shift
  always_comb begin
    tz = ShW'(p_max_shift);
    for (int i = int'(p_max_shift) - 1; i >= 0; i--) begin
      if (b_reg[i]) tz = ShW'(i);
    end
  end

  // Add steps consume exactly one bit of b; skip steps consume the zero run
  always_comb begin
    shamt          = b_reg[0] ? ShW'(1) : tz;
    a_shl          = a_reg << shamt;
    b_shr          = b_reg >> shamt;
    sum            = result_reg + a_reg;
    b_is_zero      = (b_reg == '0);
    b_next_is_zero = (b_shr == '0);
    b_lsb          = b_reg[0];
    result         = result_reg;
  end

  // Operand load on accept, one shift(-and-add) step per CALC cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
    end else if (load) begin
      a_reg      <= in_a;
      b_reg      <= in_b;
      result_reg <= '0;
    end else if (calc && !b_is_zero) begin
      a_reg <= a_shl;
      b_reg <= b_shr;
      if (b_lsb) result_reg <= sum;
    end
  end

endmodule

// File: rtl/int_mul_iter_var.sv
// Iterative 32-bit multiplier with val/rdy streams; returns low p_nbits of a*b.
// Latency depends on b: each CALC cycle consumes one set bit or a zero run.
module int_mul_iter_var
  import int_mul_iter_var_pkg::*;
#(
  parameter int unsigned p_nbits     = NBits,
  parameter int unsigned p_max_shift = MaxShift
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 istream_val,
  output logic                 istream_rdy,
  input  logic [2*p_nbits-1:0] istream_msg,
  output logic                 ostream_val,
  input  logic                 ostream_rdy,
  output logic [p_nbits-1:0]   ostream_msg
);

  state_t state;
  logic   load, calc;
  logic   b_is_zero, b_next_is_zero, b_lsb;

  assign istream_rdy = (state == StIdle) && !reset;
  assign ostream_val = (state == StDone) && !reset;
  assign load        = istream_val && istream_rdy;
  assign calc        = (state == StCalc);

  int_mul_iter_var_dpath #(
    .p_nbits     (p_nbits),
    .p_max_shift (p_max_shift)
  ) u_dpath (
    .clk            (clk),
    .reset          (reset),
    .load           (load),
    .calc           (calc),
    .in_a           (istream_msg[2*p_nbits-1:p_nbits]),
    .in_b           (istream_msg[p_nbits-1:0]),
    .b_is_zero      (b_is_zero),
    .b_next_is_zero (b_next_is_zero),
    .b_lsb          (b_lsb),
    .result         (ostream_msg)
  );

  // Control FSM: accept in IDLE, iterate in CALC, hold response in DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= StIdle;
    end else begin
      unique case (state)
        StIdle: if (load) state <= StCalc;
        StCalc: if (b_is_zero || b_next_is_zero) state <= StDone;
        StDone: if (ostream_rdy) state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_int_mul_iter_var.sv
// Directed and randomized checks of int_mul_iter_var against a behavioural model.
module tb_int_mul_iter_var;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        istream_val = 1'b0;
  logic        istream_rdy;
  logic [63:0] istream_msg = '0;
  logic        ostream_val;
  logic        ostream_rdy = 1'b0;
  logic [31:0] ostream_msg;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  int_mul_iter_var dut (
    .clk         (clk),
    .reset       (reset),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .istream_msg (istream_msg),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .ostream_msg (ostream_msg)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Number of CALC cycles: each cycle retires one set LSB or up to 4 zeros.
  function automatic int calc_cycles(input logic [31:0] b);
    int          n;
    int          s;
    logic [31:0] bb;
    n  = 0;
    bb = b;
    if (bb == 0) return 1;
    while (bb != 0) begin
      if (bb[0]) begin
        bb = bb >> 1;
      end else begin
        s = 0;
        while (s < 4 && !bb[s]) s++;
        bb = bb >> s;
      end
      n++;
    end
    return n;
  endfunction

  task automatic run_txn(input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit rdy_early);
    logic [31:0] exp;
    int          lat;
    int          waited;
    bit          seen;
    exp = a * b;
    @(negedge clk);
    waited = 0;
    while (!istream_rdy && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("istream_rdy_before_req", istream_rdy, 1'b1);
    istream_val = 1'b1;
    istream_msg = {a, b};
    ostream_rdy = 1'b0;
    @(posedge clk);
    #1;
    istream_val = 1'b0;
    istream_msg = {$urandom, $urandom};
    if (rdy_early) ostream_rdy = 1'b1;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      check("istream_rdy_busy", istream_rdy, 1'b0);
      @(posedge clk);
      #1;
      lat++;
      seen = ostream_val;
    end
    check("latency", lat, calc_cycles(b));
    check("product", ostream_msg, exp);
    if (!rdy_early) begin
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        istream_msg = {$urandom, $urandom};
        check("hold_val", ostream_val, 1'b1);
        check("hold_msg", ostream_msg, exp);
        check("hold_istream_rdy", istream_rdy, 1'b0);
      end
      @(negedge clk);
      ostream_rdy = 1'b1;
    end
    @(posedge clk);
    #1;
    ostream_rdy = 1'b0;
    check("post_hs_val", ostream_val, 1'b0);
    check("post_hs_rdy", istream_rdy, 1'b1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    // Reset behaviour
    @(negedge clk);
    check("reset_istream_rdy", istream_rdy, 1'b0);
    check("reset_ostream_val", ostream_val, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("after_reset_rdy", istream_rdy, 1'b1);
    check("after_reset_val", ostream_val, 1'b0);
    check("after_reset_msg", ostream_msg, 32'h0);

    // Directed cases
    run_txn(32'd3, 32'd4, 0, 1'b1);
    run_txn(32'h12345678, 32'h0, 0, 1'b0);
    run_txn(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1'b0);
    run_txn(32'hFFFFFFFE, 32'd3, 0, 1'b0);
    run_txn(32'd7, 32'h80000000, 2, 1'b0);
    run_txn(32'hDEADBEEF, 32'h00010001, 5, 1'b0);

    // Reset pulse during CALC drops the in-flight transaction
    @(negedge clk);
    istream_val = 1'b1;
    istream_msg = {32'h11111111, 32'hFFFFFFFF};
    @(posedge clk);
    #1;
    istream_val = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midcalc_reset_rdy", istream_rdy, 1'b0);
    check("midcalc_reset_val", ostream_val, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midcalc_after_rdy", istream_rdy, 1'b1);
    check("midcalc_after_val", ostream_val, 1'b0);
    check("midcalc_after_msg", ostream_msg, 32'h0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check("no_stale_resp", ostream_val, 1'b0);
    end
    run_txn(32'd5, 32'd5, 0, 1'b0);

    // Randomized operands with mixed bit densities and backpressure
    for (int t = 0; t < 30; t++) begin
      ra = $urandom;
      case (t % 4)
        0: rb = $urandom;
        1: rb = $urandom & $urandom & $urandom;
        2: rb = 32'h1 << $urandom_range(31, 0);
        default: rb = $urandom_range(255, 0);
      endcase
      run_txn(ra, rb, $urandom_range(3, 0), ($urandom_range(1, 0) == 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
